sys_pll_reset_sequencer: RTL

//  Consumer end of the system PLL rst/locked interface: drives PLL rst and watches locked.

---
 rtl/sys_pll_seq_pkg.sv | 17 +
 rtl/sys_pll_seq_sync.sv | 28 ++
 rtl/sys_pll_reset_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sys_pll_seq_pkg.sv
// Purpose : shared types and constants for the system PLL reset sequencer.
// Contents: sequencer state encoding, relock counter width and saturation value.
// Used by : sys_pll_reset_sequencer (import sys_pll_seq_pkg::*).
package sys_pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } seq_state_e;

    localparam int RELOCK_CNT_W = 8;
    localparam logic [RELOCK_CNT_W-1:0] RELOCK_CNT_MAX = '1;

endpackage

// File: rtl/sys_pll_seq_sync.sv
// Purpose : 2-flop synchroniser for asynchronous level inputs; resets to 0.
// Latency : an input edge appears on q_o two clk_i edges later.
// Ports   : clk_i, rst_n_i (async active-low), d_i (async), q_o (synchronised).
module sys_pll_seq_sync #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sys_pll_reset_sequencer.sv
// Purpose : pulses PLL reset, waits for lock (timeout + retry), qualifies lock
//           stability, releases system reset, re-sequences on lock loss or sw request.
// Latency : pll_locked rise to sys_reset_n rise = 2 (sync) + 1 + LOCK_STABLE_CYCLES refclk cycles.
// Ports   : refclk, rst_n (async active-low), pll_locked (async), sw_reset_req (1-cycle pulse)
//           -> pll_rst, sys_reset_n, pll_ready, lock_fail, relock_count[7:0]; all registered.
// Config  : define SYS_PLL_SEQ_GLITCH_FILTER_EN to require LOSS_FILTER_CYCLES consecutive
//           unlocked cycles in RUN before a lock loss is declared.
module sys_pll_reset_sequencer
    import sys_pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned LOSS_FILTER_CYCLES  = 4,
    parameter int unsigned CNT_W               = 20
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic                    sw_reset_req,
    output logic                    pll_rst,
    output logic                    sys_reset_n,
    output logic                    pll_ready,
    output logic                    lock_fail,
    output logic [RELOCK_CNT_W-1:0] relock_count
);

    // Retry counter must hold MAX_RETRIES itself (value seen on the way into FAIL).
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

    seq_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RETRY_W-1:0]      retry_q, retry_d;
    logic [RELOCK_CNT_W-1:0] relock_q, relock_d;
    logic                    pll_rst_q, pll_rst_d;
    logic                    sys_reset_n_q, sys_reset_n_d;
    logic                    pll_ready_q, pll_ready_d;
    logic                    lock_fail_q, lock_fail_d;

    logic lk;
    logic lock_lost;

    sys_pll_seq_sync #(
        .W (1)
    ) u_lock_sync (
        .clk_i   (refclk),
        .rst_n_i (rst_n),
        .d_i     (pll_locked),
        .q_o     (lk)
    );

`ifdef SYS_PLL_SEQ_GLITCH_FILTER_EN
    localparam int FILT_W = $clog2(LOSS_FILTER_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER_CYCLES - 1);

    logic [FILT_W-1:0] filt_q, filt_d;

    // Counts consecutive unlocked cycles in RUN; any locked cycle clears it,
    // so short dropouts never reach the FSM.
    always_comb begin
        filt_d    = '0;
        lock_lost = 1'b0;
        if ((state_q == RUN) && !lk) begin
            if (filt_q == FILT_LAST) begin
                lock_lost = 1'b1;
            end else begin
                filt_d = filt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt_d;
        end
    end
`else
    assign lock_lost = (state_q == RUN) && !lk;

    // Filter length has no meaning without the filter; nothing is built here.
    if (LOSS_FILTER_CYCLES == 0) begin : g_no_filter_cfg
    end
`endif

    // Next-state logic. One counter is shared by the PLL_RST pulse, the lock
    // timeout and the stability window since only one is live per state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        relock_d = relock_q;

        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + 1'b1;
                    cnt_d   = '0;
                    // retry_q is the count before this attempt is charged.
                    state_d = (retry_q == RETRY_LAST) ? FAIL : PLL_RST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE: begin
                if (!lk) begin
                    // Lock bounced: keep the PLL running, restart the timeout,
                    // and do not charge a retry.
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (lock_lost) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    if (relock_q != RELOCK_CNT_MAX) begin
                        relock_d = relock_q + 1'b1;
                    end
                end
            end
            FAIL: begin
                // Held until software or rst_n intervenes.
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Software request overrides everything except an ongoing PLL reset
        // pulse, which it must not stretch. Relock accounting above still applies.
        if (sw_reset_req && (state_q != PLL_RST)) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        pll_rst_d     = (state_d == PLL_RST) || (state_d == FAIL);
        sys_reset_n_d = (state_d == RUN);
        pll_ready_d   = (state_d == RUN);
        lock_fail_d   = (state_d == FAIL);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PLL_RST;
            cnt_q         <= '0;
            retry_q       <= '0;
            relock_q      <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            pll_ready_q   <= 1'b0;
            lock_fail_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            relock_q      <= relock_d;
            pll_rst_q     <= pll_rst_d;
            sys_reset_n_q <= sys_reset_n_d;
            pll_ready_q   <= pll_ready_d;
            lock_fail_q   <= lock_fail_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_reset_n  = sys_reset_n_q;
    assign pll_ready    = pll_ready_q;
    assign lock_fail    = lock_fail_q;
    assign relock_count = relock_q;

endmodule
